// File: rtl/axi4_lite_manager.sv
// axi4_lite_manager: single-outstanding request/response port to AXI4-Lite manager bridge
module axi4_lite_manager #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   resp_rdata,
    output logic                        resp_err,
    output logic                        axi_awvalid,
    input  logic                        axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [2:0]                  axi_awprot,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                        axi_bvalid,
    output logic                        axi_bready,
    input  logic [1:0]                  axi_bresp,
    output logic                        axi_arvalid,
    input  logic                        axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
    output logic [2:0]                  axi_arprot,
    input  logic                        axi_rvalid,
    output logic                        axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]                  axi_rresp
);
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;
    state_t state, state_n;
    logic   accept, aw_ok, w_ok;
    assign axi_awprot = 3'b000;
    assign axi_arprot = 3'b000;
    assign req_ready  = state == IDLE;
    assign accept     = req_ready && req_valid;
    // A channel counts as done once its valid has dropped or is handshaking now
    assign aw_ok      = !axi_awvalid || axi_awready;
    assign w_ok       = !axi_wvalid || axi_wready;
    always_ff @(posedge aclk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req_valid ? (req_we ? WRITE : RADDR) : IDLE;
            WRITE:   state_n = (aw_ok && w_ok) ? WRESP : WRITE;
            WRESP:   state_n = (axi_bvalid && axi_bready) ? RESP : WRESP;
            RADDR:   state_n = axi_arready ? RDATA : RADDR;
            RDATA:   state_n = (axi_rvalid && axi_rready) ? RESP : RDATA;
            RESP:    state_n = resp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge aclk) begin
        if (rst) begin
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            axi_awaddr  <= '0;
            axi_araddr  <= '0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
        end else begin
            if (accept && req_we) begin
                axi_awaddr <= req_addr;
                axi_wdata  <= req_wdata;
                axi_wstrb  <= req_wstrb;
            end
            if (accept && !req_we) axi_araddr <= req_addr;
            axi_awvalid <= (accept && req_we) || (axi_awvalid && !axi_awready);
            axi_wvalid  <= (accept && req_we) || (axi_wvalid && !axi_wready);
            axi_bready  <= state_n == WRESP;
            axi_arvalid <= state_n == RADDR;
            axi_rready  <= state_n == RDATA;
            resp_valid  <= state_n == RESP;
            if (axi_bvalid && axi_bready) begin
                resp_rdata <= '0;
                resp_err   <= |axi_bresp;
            end
            if (axi_rvalid && axi_rready) begin
                resp_rdata <= axi_rdata;
                resp_err   <= |axi_rresp;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_manager.sv
// tb_axi4_lite_manager: directed self-checking bench for axi4_lite_manager
module tb_axi4_lite_manager;
    logic        aclk = 0, rst = 1;
    logic        req_valid = 0, req_ready, req_we = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_wstrb = 0;
    logic        resp_valid, resp_ready = 0, resp_err;
    logic [31:0] resp_rdata;
    logic        axi_awvalid, axi_awready = 0, axi_wvalid, axi_wready = 0;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata = 0;
    logic [2:0]  axi_awprot, axi_arprot;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid = 0, axi_bready, axi_arvalid, axi_arready = 0;
    logic        axi_rvalid = 0, axi_rready;
    logic [1:0]  axi_bresp = 0, axi_rresp = 0;
    logic [31:0] mem [16];
    int          errors = 0, checks = 0, bcnt = 0;

    axi4_lite_manager dut (
        .aclk(aclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (axi_bvalid && axi_bready) bcnt <= bcnt + 1;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic consume;
        resp_ready = 1;
        tick;
        resp_ready = 0;
    endtask

    // Zero-wait subordinate backed by mem; leaves the response pending
    task automatic run(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] r);
        int n;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        axi_awready = 1; axi_wready = 1; axi_arready = 1;
        axi_bvalid = 1; axi_rvalid = 1; axi_bresp = r; axi_rresp = r;
        axi_rdata = mem[a[5:2]];
        if (we) for (int i = 0; i < 4; i++) if (s[i]) mem[a[5:2]][8*i+:8] = d[8*i+:8];
        tick;
        req_valid = 0;
        n = 1;
        while (!resp_valid && n < 20) begin
            tick;
            n++;
        end
        chk("latency", n, 3);
        axi_awready = 0; axi_wready = 0; axi_arready = 0;
        axi_bvalid = 0; axi_rvalid = 0; axi_bresp = 0; axi_rresp = 0;
    endtask

    task automatic split(input bit aw_first);
        req_valid = 1; req_we = 1; req_addr = 32'h8; req_wdata = 32'h11223344; req_wstrb = 4'h3;
        tick;
        req_valid = 0;
        chk("split_both_valid", {axi_awvalid, axi_wvalid}, 2'b11);
        if (aw_first) axi_awready = 1; else axi_wready = 1;
        tick;
        axi_awready = 0; axi_wready = 0;
        chk("split_first_drop", {axi_awvalid, axi_wvalid}, aw_first ? 2'b01 : 2'b10);
        repeat (2) begin
            tick;
            chk("split_hold", {axi_awvalid, axi_wvalid, axi_bready}, aw_first ? 3'b010 : 3'b100);
            chk("split_awaddr", axi_awaddr, 32'h8);
            chk("split_wdata", {axi_wdata, axi_wstrb}, {32'h11223344, 4'h3});
        end
        if (aw_first) axi_wready = 1; else axi_awready = 1;
        tick;
        axi_awready = 0; axi_wready = 0;
        chk("split_done", {axi_awvalid, axi_wvalid, axi_bready}, 3'b001);
        axi_bvalid = 1;
        tick;
        axi_bvalid = 0;
        chk("split_resp", {resp_valid, resp_err, axi_bready}, 3'b100);
        chk("split_rdata", resp_rdata, 0);
        consume;
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 0;
        tick; tick;
        chk("rst_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, resp_valid}, 0);
        chk("rst_data", {axi_awaddr, axi_araddr, axi_wdata, axi_wstrb, resp_rdata, resp_err}, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("prot", {axi_awprot, axi_arprot}, 0);
        rst = 0;

        // zero-wait write with early bvalid
        req_valid = 1; req_we = 1; req_addr = 32'h40; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
        axi_awready = 1; axi_wready = 1; axi_bvalid = 1;
        tick;
        req_valid = 0;
        chk("w_plus1", {axi_awvalid, axi_wvalid, axi_bready, req_ready}, 4'b1100);
        chk("w_fields", {axi_awaddr, axi_wdata, axi_wstrb}, {32'h40, 32'hDEADBEEF, 4'hF});
        tick;
        chk("w_plus2", {axi_awvalid, axi_wvalid, axi_bready, resp_valid}, 4'b0010);
        tick;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
        chk("w_plus3", {resp_valid, resp_err, axi_bready, req_ready}, 4'b1000);
        chk("w_rdata", resp_rdata, 0);
        consume;
        chk("w_idle", {resp_valid, req_ready}, 2'b01);

        split(0);
        split(1);
        chk("b_count", bcnt, 3);

        // read with wait states
        req_valid = 1; req_we = 0; req_addr = 32'h100;
        tick;
        req_valid = 0;
        chk("r_ar1", {axi_arvalid, axi_rready}, 2'b10);
        chk("r_araddr1", axi_araddr, 32'h100);
        tick;
        chk("r_ar2", {axi_arvalid, axi_rready}, 2'b10);
        chk("r_araddr2", axi_araddr, 32'h100);
        axi_arready = 1;
        tick;
        axi_arready = 0;
        chk("r_rready", {axi_arvalid, axi_rready}, 2'b01);
        repeat (3) begin
            tick;
            chk("r_wait", {axi_rready, resp_valid, axi_araddr}, {2'b10, 32'h100});
        end
        axi_rvalid = 1; axi_rdata = 32'h12345678;
        tick;
        axi_rvalid = 0; axi_rdata = 0;
        chk("r_resp", {resp_valid, resp_err, axi_rready}, 3'b100);
        chk("r_rdata", resp_rdata, 32'h12345678);
        consume;

        // error responses
        run(1, 32'h10, 32'h1, 4'hF, 2'b10);
        chk("werr", {resp_valid, resp_err}, 2'b11);
        consume;
        run(0, 32'h10, 32'h0, 4'h0, 2'b11);
        chk("rerr", {resp_valid, resp_err}, 2'b11);
        chk("rerr_data", resp_rdata, 32'h1);
        consume;

        // backpressure with a queued read behind a write
        run(1, 32'h4, 32'hA5A5A5A5, 4'hF, 2'b00);
        req_valid = 1; req_we = 0; req_addr = 32'h4;
        repeat (5) begin
            chk("bp_hold", {resp_valid, req_ready, resp_err, resp_rdata}, {3'b100, 32'h0});
            tick;
        end
        consume;
        chk("bp_release", {resp_valid, req_ready, axi_arvalid}, 3'b010);
        run(0, 32'h4, 32'h0, 4'h0, 2'b00);
        chk("b2b_read", {resp_err, resp_rdata}, {1'b0, 32'hA5A5A5A5});
        consume;
        chk("b2b_idle", req_ready, 1);

        // reset while waiting in WRESP
        req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        axi_awready = 1; axi_wready = 1;
        tick;
        req_valid = 0;
        tick;
        axi_awready = 0; axi_wready = 0;
        chk("rst_mid_wresp", axi_bready, 1);
        rst = 1;
        tick;
        chk("rst_mid_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, resp_valid}, 0);
        chk("rst_mid_data", {axi_awaddr, axi_wdata, axi_wstrb}, 0);
        rst = 0; axi_bvalid = 1;
        tick;
        chk("rst_mid_ready", {req_ready, resp_valid, axi_bready}, 3'b100);
        repeat (3) begin
            tick;
            chk("rst_no_resp", {resp_valid, axi_awvalid, axi_bready}, 0);
        end
        axi_bvalid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
